// File: rtl/data_mem_unit.sv
// Memory-mapped data port for the core MEM stage: word RAM plus GPIO, a free-running
// cycle counter and a 4-deep FIFO feeding an 8N1 UART transmitter.
module data_mem_unit #(
    parameter int DEPTH        = 16,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ram_in_address,
    input  logic [31:0] ram_in_data,
    input  logic        ram_in_write,
    output logic [31:0] ram_out,
    input  logic [7:0]  gpio_in,
    output logic [7:0]  gpio_out,
    output logic        uart_tx
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    logic [31:0] mem [DEPTH];
    logic [31:0] cycle;
    logic [7:0]  sync1, sync2;
    logic [7:0]  fifo [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  count;
    logic        overflow;

    tx_state_t   state, state_next;
    logic [BW-1:0] baud, baud_next;
    logic [2:0]  bit_idx, bit_next;
    logic [7:0]  shift, shift_next;
    logic        tx_next, pop;

    logic in_ram, push, stat_wr, empty, full, busy, accept, ovf_event;

    assign in_ram    = ram_in_address < 32'(DEPTH);
    assign push      = ram_in_write && (ram_in_address == 32'h103);
    assign stat_wr   = ram_in_write && (ram_in_address == 32'h104);
    assign empty     = (count == 3'd0);
    assign full      = (count == 3'd4);
    assign busy      = (state != IDLE);
    // A pop in the same cycle frees the slot the push lands in.
    assign accept    = push && (!full || pop);
    assign ovf_event = push && full && !pop;

    always_ff @(posedge clk) begin
        if (ram_in_write && in_ram)
            mem[ram_in_address[AW-1:0]] <= ram_in_data;
        if (accept)
            fifo[wr_ptr] <= ram_in_data[7:0];
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            gpio_out <= '0;
            cycle    <= '0;
            sync1    <= '0;
            sync2    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            cycle <= cycle + 32'd1;
            sync1 <= gpio_in;
            sync2 <= sync1;
            if (ram_in_write && ram_in_address == 32'h100)
                gpio_out <= ram_in_data[7:0];
            if (accept)
                wr_ptr <= wr_ptr + 2'd1;
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            count <= count + {2'b0, accept} - {2'b0, pop};
            if (ovf_event)
                overflow <= 1'b1;
            else if (stat_wr)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            uart_tx <= 1'b1;
        end else begin
            state   <= state_next;
            baud    <= baud_next;
            bit_idx <= bit_next;
            shift   <= shift_next;
            uart_tx <= tx_next;
        end
    end

    // tx_next is the line level for the state being entered, so uart_tx stays a flop.
    always_comb begin
        state_next = state;
        baud_next  = baud;
        bit_next   = bit_idx;
        shift_next = shift;
        tx_next    = uart_tx;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = fifo[rd_ptr];
                    baud_next  = '0;
                    state_next = START;
                    tx_next    = 1'b0;
                end
            end
            START: begin
                if (baud == BAUD_MAX) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = DATA;
                    tx_next    = shift[0];
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
            DATA: begin
                if (baud == BAUD_MAX) begin
                    baud_next = '0;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_next   = bit_idx + 3'd1;
                        shift_next = {1'b0, shift[7:1]};
                        tx_next    = shift[1];
                    end
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
            STOP: begin
                tx_next = 1'b1;
                if (baud == BAUD_MAX) begin
                    baud_next  = '0;
                    state_next = IDLE;
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ram_out = '0;
        if (in_ram) begin
            ram_out = mem[ram_in_address[AW-1:0]];
        end else begin
            case (ram_in_address)
                32'h100: ram_out = {24'b0, gpio_out};
                32'h101: ram_out = {24'b0, sync2};
                32'h102: ram_out = cycle;
                32'h104: ram_out = {28'b0, overflow, busy, full, empty};
                default: ram_out = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit; a serial receiver checks transmitted bytes
// against a scoreboard queue filled when UART_DATA writes are driven.
module tb_data_mem_unit;
    localparam int DEPTH = 16;
    localparam int CPB   = 4;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [31:0] ram_in_address = '0;
    logic [31:0] ram_in_data = '0;
    logic        ram_in_write = 1'b0;
    logic [31:0] ram_out;
    logic [7:0]  gpio_in = '0;
    logic [7:0]  gpio_out;
    logic        uart_tx;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];

    data_mem_unit #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .clr(clr),
        .ram_in_address(ram_in_address), .ram_in_data(ram_in_data),
        .ram_in_write(ram_in_write), .ram_out(ram_out),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        ram_in_address = a;
        ram_in_write   = 1'b0;
        #1;
        chk(tag, ram_out, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        ram_in_address = a;
        ram_in_data    = d;
        ram_in_write   = 1'b1;
        @(negedge clk);
        ram_in_write   = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit expect_tx);
        if (expect_tx) sb.push_back(b);
        wr(32'h103, {24'hFFFFFF, b});
    endtask

    // Serial receiver: samples mid-bit, discards any frame cut by clr.
    initial begin : rx_mon
        logic [7:0] b;
        bit bad;
        forever begin
            @(negedge clk);
            if (!clr && uart_tx === 1'b0) begin
                bad = 1'b0;
                @(negedge clk);
                if (clr) bad = 1'b1;
                else chk("rx_start", {31'b0, uart_tx}, 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) begin
                        @(negedge clk);
                        if (clr) bad = 1'b1;
                    end
                    b[i] = uart_tx;
                end
                repeat (CPB) begin
                    @(negedge clk);
                    if (clr) bad = 1'b1;
                end
                if (!bad) begin
                    chk("rx_stop", {31'b0, uart_tx}, 32'd1);
                    if (sb.size() > 0) chk("rx_byte", {24'b0, b}, {24'b0, sb.pop_front()});
                    else chk("rx_unexpected_byte", 32'(sb.size()), 32'd1);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [9:0] pat;
        pat = {1'b1, 8'h55, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_gpio_out", {24'b0, gpio_out}, 32'd0);
        chk("rst_uart_tx", {31'b0, uart_tx}, 32'd1);
        rd(32'h102, 32'd0, "rst_cycle");
        rd(32'h104, 32'd1, "rst_status");
        rd(32'h101, 32'd0, "rst_gpio_in");

        clr = 1'b0;
        rd(32'h102, 32'd0, "cycle_at_release");
        @(negedge clk); rd(32'h102, 32'd1, "cycle_first_incr");
        repeat (3) @(negedge clk);
        rd(32'h102, 32'd4, "cycle_count");

        // RAM write/read, same-cycle old value, top word, unmapped
        wr(32'd5, 32'h1111_1111);
        ram_in_address = 32'd5; ram_in_data = 32'hDEAD_BEEF; ram_in_write = 1'b1;
        #1 chk("ram_same_cycle_old", ram_out, 32'h1111_1111);
        @(negedge clk); ram_in_write = 1'b0;
        #1 chk("ram_readback", ram_out, 32'hDEAD_BEEF);
        wr(32'd0, 32'hA0A0_A0A0);
        wr(DEPTH - 1, 32'hCAFE_F00D);
        rd(DEPTH - 1, 32'hCAFE_F00D, "ram_top_word");
        wr(DEPTH, 32'h1234_5678);
        rd(DEPTH, 32'd0, "unmapped_read_zero");
        rd(32'd0, 32'hA0A0_A0A0, "unmapped_write_no_alias");
        rd(32'h103, 32'd0, "uart_data_reads_zero");

        // GPIO out and read-only GPIO in
        wr(32'h100, 32'h1A5);
        chk("gpio_out_written", {24'b0, gpio_out}, 32'hA5);
        rd(32'h100, 32'hA5, "gpio_out_read");
        wr(32'h101, 32'hFF);
        rd(32'h101, 32'd0, "gpio_in_write_ignored");
        chk("gpio_out_unchanged", {24'b0, gpio_out}, 32'hA5);

        // Synchronizer latency
        @(negedge clk);
        gpio_in = 8'h3C; ram_in_address = 32'h101;
        @(posedge clk); #1 chk("gpio_in_1edge", ram_out, 32'd0);
        @(posedge clk); #1 chk("gpio_in_2edge", ram_out, 32'h3C);
        @(negedge clk);

        // Single frame with exact bit timing
        push_byte(8'h55, 1'b1);
        chk("tx_idle_before_pop", {31'b0, uart_tx}, 32'd1);
        rd(32'h104, 32'd0, "status_queued");
        for (int j = 0; j < 10 * CPB; j++) begin
            @(negedge clk);
            chk($sformatf("tx_pattern_%0d", j), {31'b0, uart_tx}, {31'b0, pat[j / CPB]});
            if (j == 0) chk("status_busy_empty", ram_out, 32'h5);
        end
        @(negedge clk);
        chk("tx_idle_after_frame", {31'b0, uart_tx}, 32'd1);
        rd(32'h104, 32'd1, "status_idle_after_frame");

        // Burst: 1 popped + 4 queued, 6th dropped
        push_byte(8'h01, 1'b1);
        push_byte(8'h80, 1'b1);
        push_byte(8'hFF, 1'b1);
        push_byte(8'h5A, 1'b1);
        push_byte(8'hC3, 1'b1);
        push_byte(8'h7E, 1'b0);
        rd(32'h104, 32'hE, "status_overflow_full");
        wr(32'h104, 32'd0);
        rd(32'h104, 32'h6, "status_overflow_cleared");
        for (int i = 0; i < 600 && sb.size() > 0; i++) @(negedge clk);
        chk("burst_drained", 32'(sb.size()), 32'd0);
        repeat (6) @(negedge clk);
        rd(32'h104, 32'd1, "status_idle_after_burst");

        // Abort mid-DATA with two bytes queued
        push_byte(8'h00, 1'b0);
        push_byte(8'h00, 1'b0);
        push_byte(8'h00, 1'b0);
        repeat (12) @(negedge clk);
        chk("tx_low_mid_data", {31'b0, uart_tx}, 32'd0);
        #2 clr = 1'b1;
        #1 chk("tx_async_abort", {31'b0, uart_tx}, 32'd1);
        chk("clr_gpio_out", {24'b0, gpio_out}, 32'd0);
        repeat (2) @(negedge clk);
        clr = 1'b0;
        rd(32'h104, 32'd1, "status_after_clr");
        rd(32'h102, 32'd0, "cycle_restart");
        @(negedge clk);
        rd(32'h102, 32'd1, "cycle_after_restart");
        rd(32'd5, 32'hDEAD_BEEF, "ram_persist");
        repeat (60) @(negedge clk);
        chk("tx_queue_discarded", {31'b0, uart_tx}, 32'd1);
        rd(32'h104, 32'd1, "status_still_empty");

        chk("sb_empty_end", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_mem_unit.md
DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 Parameter DEPTH, default 16, number of 32-bit data RAM words (power of 2, 2..256).
REQ-002 Parameter CLKS_PER_BIT, default 4, clock cycles per UART bit (>=1).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 clr  input  1  reset, asynchronous, active-high.
REQ-005 ram_in_address  input  32  word address from the core MEM stage.
REQ-006 ram_in_data  input  32  write data from the core.
REQ-007 ram_in_write  input  1  write strobe from the core.
REQ-008 ram_out  output  32  read data to the core MEMWB register.
REQ-009 gpio_in  input  8  asynchronous external inputs.
REQ-010 gpio_out  output  8  registered GPIO outputs.
REQ-011 uart_tx  output  1  registered serial transmit line, idle high.

Function
REQ-012 Address map: 0x000..DEPTH-1 data RAM; 0x100 GPIO_OUT (R/W); 0x101 GPIO_IN (R); 0x102 CYCLE (R); 0x103 UART_DATA (W); 0x104 UART_STATUS (R, write clears overflow); all other addresses read 0, writes ignored.
REQ-013 ram_out is combinational from ram_in_address and current register state; zero read latency.
REQ-014 Writes take effect at the rising edge where ram_in_write=1; a read of the same address in that cycle returns the old value.
REQ-015 Writes to read-only addresses have no effect.
REQ-016 GPIO_OUT write stores ram_in_data[7:0]; read returns {24'b0, gpio_out}.
REQ-017 GPIO_IN read returns {24'b0, sync2}: gpio_in passes a 2-flop synchronizer; a change becomes readable after the 2nd rising edge.
REQ-018 CYCLE: 32-bit counter, +1 every cycle, wraps 0xFFFFFFFF->0x00000000; read returns current register value.
REQ-019 UART_DATA write pushes ram_in_data[7:0] into a 4-entry FIFO; UART_DATA reads 0.
REQ-020 UART_STATUS read = {28'b0, overflow, busy, full, empty}; busy=1 when TX FSM not IDLE.
REQ-021 Push while full and no pop in that cycle: byte dropped, FIFO unchanged, overflow set (sticky).
REQ-022 Push while full with a pop in the same cycle: push accepted; count unchanged.
REQ-023 Any write to 0x104 clears overflow; a simultaneous new overflow event wins (overflow stays 1).
REQ-024 FIFO pointers wrap modulo 4; empty/full derived from a 3-bit count.
REQ-025 TX FSM states IDLE, START, DATA, STOP; a bit counter and a 0..CLKS_PER_BIT-1 baud counter.
REQ-026 IDLE: uart_tx=1; if FIFO non-empty at an edge, pop head into shift register, go START.
REQ-027 START: uart_tx=0 for CLKS_PER_BIT cycles, then DATA.
REQ-028 DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles, then STOP.
REQ-029 STOP: uart_tx=1 for CLKS_PER_BIT cycles, then IDLE; next byte pops no earlier than the edge after STOP ends (frame = 10*CLKS_PER_BIT cycles + 1 IDLE cycle).
REQ-030 Push into empty FIFO at edge N: IDLE pops at edge N+1; uart_tx falls after edge N+1.

Reset
REQ-031 While clr=1: gpio_out=0, uart_tx=1, CYCLE=0, synchronizer=0, FIFO empty, overflow=0, TX FSM IDLE, all counters 0.
REQ-032 Data RAM contents are not reset and persist across clr.
REQ-033 clr asserted mid-frame aborts the frame immediately (uart_tx=1 asynchronously) and discards queued bytes.
REQ-034 First CYCLE increment occurs at the first rising edge after clr deasserts.

Verification
REQ-035 Write 0xDEADBEEF to 0x005, then read 0x005 next cycle -> ram_out=0xDEADBEEF; same-cycle read returns prior value.
REQ-036 Write 0x1A5 to 0x100 -> gpio_out=0xA5 after the edge; read 0x100 -> 0x000000A5; write to 0x101 -> no change.
REQ-037 Set gpio_in=0x3C -> read 0x101 returns 0 after 1 edge, 0x0000003C after 2 edges.
REQ-038 CLKS_PER_BIT=4, push 0x55 -> uart_tx pattern 0,1,0,1,0,1,0,1,0,1 (start, LSB first, stop), each bit 4 cycles; STATUS busy=1 during frame, empty=1 after pop.
REQ-039 Push 6 bytes back-to-back while a frame is in progress -> first 4 queued after one pop... exact: 1 popped + 4 queued accepted, 6th dropped, STATUS overflow=1; write 0x104 -> overflow=0; transmitted order matches push order.
REQ-040 Assert clr mid-DATA with 2 bytes queued -> uart_tx=1 immediately, STATUS=0x1 after release, CYCLE restarts from 0, RAM word 0x005 still 0xDEADBEEF.
